// File: rtl/regfile16_flags_pkg.sv
// Shared nand2cpu datapath definitions: widths, flag bit positions and alu16 opcodes.
// The register file, the flag register and the benches all import these.
package regfile16_flags_pkg;

  localparam int WIDTH = 16;
  localparam int AW    = 3;
  localparam int NREGS = 1 << AW;

  // Bit positions of C/Z/N inside a packed flag word
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

endpackage

// File: rtl/regfile16_flags_flags_reg.sv
// Status-flag register (C, Z, N) loaded from the alu16 result bus.
// Loads whenever flags_we is high, regardless of whether the result is written back.
module flags_reg16
  import regfile16_flags_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flags_we,
  input  logic             cout_in,
  input  logic [WIDTH-1:0] wr_data,
  output logic             carry_q,
  output logic             zero_q,
  output logic             neg_q
);

  logic [2:0] flags;
  logic [2:0] flags_next;

  always_comb begin
    flags_next         = '0;
    flags_next[FLAG_C] = cout_in;
    flags_next[FLAG_Z] = (wr_data == '0);
    flags_next[FLAG_N] = wr_data[WIDTH-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           flags <= '0;
    else if (flags_we) flags <= flags_next;
  end

  assign carry_q = flags[FLAG_C];
  assign zero_q  = flags[FLAG_Z];
  assign neg_q   = flags[FLAG_N];

endmodule

// File: rtl/regfile16_flags.sv
// Operand register file (R0 hardwired to zero) plus C/Z/N flags for the nand2cpu datapath.
// Two combinational read ports feed alu16; its result and carry are written back on the clock edge.
module regfile16_flags
  import regfile16_flags_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             flags_we,
  input  logic             cout_in,
  output logic             carry_q,
  output logic             zero_q,
  output logic             neg_q
);

  // Storage for R1..R(NREGS-1); R0 is a constant and has no flops
  logic [WIDTH-1:0] regs [1:NREGS-1];

  // NOTE: the array is reset because software relies on every register reading 0 after reset;
  // NOTE: a plain RAM without reset would be cheaper but would break that guarantee.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        regs <= '{default: '0};
    else if (we && wr_addr != '0)   regs[wr_addr] <= wr_data;
  end

  // Reads see the stored value only; no write bypass, so the ALU loop stays acyclic.
  // NOTE: defaults come first in always_comb so no path leaves an output unassigned (no latch).
  always_comb begin
    ra_data = '0;
    rb_data = '0;
    if (ra_addr != '0) ra_data = regs[ra_addr];
    if (rb_addr != '0) rb_data = regs[rb_addr];
  end

  flags_reg16 u_flags (
    .clk      (clk),
    .rst      (rst),
    .flags_we (flags_we),
    .cout_in  (cout_in),
    .wr_data  (wr_data),
    .carry_q  (carry_q),
    .zero_q   (zero_q),
    .neg_q    (neg_q)
  );

endmodule
